mlp_stream_packer: RTL and testbench

- Producer side of the mlp_serial input interface, plus the consumer of its output.
- Accepts one quantised sample per handshake (4-bit magnitude + 2-bit polarity) from an upstream valid/ready stream and buffers one full frame of N_IN = N1/2+1 samples.
- Replays the frame to mlp_serial as a contiguous burst of N_BEATS P-lane beats on in_vld/in_mag/in_pol.
- Captures the single-cycle out_vld/out result into a held valid/ready result register for the downstream consumer.

---
 rtl/mlp_pkg.sv | 31 +++
 rtl/mlp_frame_buf.sv | 29 ++
 rtl/mlp_stream_packer.sv | 150 +++++++++++++++
 tb/tb_mlp_stream_packer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared sizing, types and state encoding for the mlp_serial input packer.
// The frame length and beat count are derived from the first-layer input count.
package mlp_pkg;

    localparam int unsigned N1      = 98;
    localparam int unsigned N2      = 10;
    localparam int unsigned P       = 2;
    localparam int unsigned W_X     = 4;
    localparam int unsigned W_K     = 4;
    localparam int unsigned W_Y     = 16;

    localparam int unsigned N_IN    = N1 / 2 + 1;
    localparam int unsigned N_BEATS = N_IN / P;
    localparam int unsigned CNT_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

    typedef struct packed {
        logic [W_X-1:0] mag;
        logic [1:0]     pol;
    } sample_t;

    typedef sample_t [P-1:0] beat_t;

    typedef enum logic [1:0] {
        FILL,
        HOLD,
        SEND,
        WAIT
    } state_e;

endpackage

// File: rtl/mlp_frame_buf.sv
// One-frame sample store: single write port, P-lane combinational beat read port.
// Contents are not reset; every entry is rewritten before it is replayed.
module mlp_frame_buf
    import mlp_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [CNT_W-1:0]  wr_idx,
    input  sample_t           wr_data,
    input  logic [BEAT_W-1:0] rd_beat,
    output beat_t             rd_data
);

    sample_t mem_q [N_IN];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned p = 0; p < P; p++) begin
            rd_data[p] = mem_q[CNT_W'(rd_beat * P + p)];
        end
    end

endmodule

// File: rtl/mlp_stream_packer.sv
// Buffers one frame of quantised samples, replays it to mlp_serial as a gapless
// P-lane burst, and holds the returned result for a valid/ready consumer.
module mlp_stream_packer
    import mlp_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [W_X-1:0]     s_mag,
    input  logic [1:0]         s_pol,
    input  logic               s_last,
    output logic               in_vld,
    output logic [P*W_X-1:0]   in_mag,
    output logic [P*2-1:0]     in_pol,
    input  logic               out_vld,
    input  logic [W_Y-1:0]     out,
    output logic               r_valid,
    input  logic               r_ready,
    output logic [W_Y-1:0]     r_data,
    output logic               err_len
);

    if ((N_IN % P) != 0) begin : g_len_chk
        $error("mlp_stream_packer: N_IN must be a multiple of P");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               in_vld_q, in_vld_d;
    logic [P*W_X-1:0]   in_mag_q, in_mag_d;
    logic [P*2-1:0]     in_pol_q, in_pol_d;
    logic               r_valid_q, r_valid_d;
    logic [W_Y-1:0]     r_data_q, r_data_d;
    logic               err_len_q, err_len_d;

    logic               accept;
    logic               last_sample;
    sample_t            wr_data;
    beat_t              rd_beat;

    assign s_ready     = (state_q == FILL) && !rst;
    assign accept      = s_valid && s_ready;
    assign last_sample = (count_q == CNT_W'(N_IN - 1));
    assign wr_data     = '{mag: s_mag, pol: s_pol};

    mlp_frame_buf u_frame_buf (
        .clk     (clk),
        .we      (accept),
        .wr_idx  (count_q),
        .wr_data (wr_data),
        .rd_beat (beat_q),
        .rd_data (rd_beat)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        beat_d    = beat_q;
        in_vld_d  = 1'b0;
        in_mag_d  = '0;
        in_pol_d  = '0;
        r_valid_d = r_valid_q && !r_ready;
        r_data_d  = r_data_q;
        err_len_d = err_len_q;

        if (out_vld && (state_q != WAIT)) begin
            err_len_d = 1'b1;
        end

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    if (s_last != last_sample) begin
                        err_len_d = 1'b1;
                    end
                    if (last_sample) begin
                        count_d = '0;
                        state_d = HOLD;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                beat_d = '0;
                if (!r_valid_q) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                // beat_q wraps to 0 after issuing the final beat, so a visible
                // beat with beat_q==0 can only be the last one of the burst.
                if (in_vld_q && (beat_q == '0)) begin
                    state_d = WAIT;
                end else begin
                    in_vld_d = 1'b1;
                    for (int unsigned p = 0; p < P; p++) begin
                        in_mag_d[p*W_X +: W_X] = rd_beat[p].mag;
                        in_pol_d[p*2 +: 2]     = rd_beat[p].pol;
                    end
                    beat_d = (beat_q == BEAT_W'(N_BEATS - 1)) ? '0 : beat_q + 1'b1;
                end
            end
            WAIT: begin
                if (out_vld) begin
                    r_data_d  = out;
                    r_valid_d = 1'b1;
                    state_d   = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FILL;
            count_q   <= '0;
            beat_q    <= '0;
            in_vld_q  <= 1'b0;
            in_mag_q  <= '0;
            in_pol_q  <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            err_len_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            beat_q    <= beat_d;
            in_vld_q  <= in_vld_d;
            in_mag_q  <= in_mag_d;
            in_pol_q  <= in_pol_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            err_len_q <= err_len_d;
        end
    end

    assign in_vld  = in_vld_q;
    assign in_mag  = in_mag_q;
    assign in_pol  = in_pol_q;
    assign r_valid = r_valid_q;
    assign r_data  = r_data_q;
    assign err_len = err_len_q;

endmodule

// File: tb/tb_mlp_stream_packer.sv
// Randomised bench for mlp_stream_packer against a frame-level reference model.
module tb_mlp_stream_packer;
    import mlp_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic [W_X-1:0]     s_mag = '0;
    logic [1:0]         s_pol = '0;
    logic               s_last = 1'b0;
    logic               in_vld;
    logic [P*W_X-1:0]   in_mag;
    logic [P*2-1:0]     in_pol;
    logic               out_vld = 1'b0;
    logic [W_Y-1:0]     out = '0;
    logic               r_valid;
    logic               r_ready = 1'b0;
    logic [W_Y-1:0]     r_data;
    logic               err_len;

    mlp_stream_packer dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_mag   (s_mag),
        .s_pol   (s_pol),
        .s_last  (s_last),
        .in_vld  (in_vld),
        .in_mag  (in_mag),
        .in_pol  (in_pol),
        .out_vld (out_vld),
        .out     (out),
        .r_valid (r_valid),
        .r_ready (r_ready),
        .r_data  (r_data),
        .err_len (err_len)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned failures = 0;

    // reference model state
    logic [W_X-1:0] frame_mag [N_IN];
    logic [1:0]     frame_pol [N_IN];
    logic           exp_err = 1'b0;
    logic           exp_rv = 1'b0;
    logic [W_Y-1:0] exp_rdata = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: mag=i%16, pol=i%4; mode 1: random samples
    task automatic send_frame(input int mode, input int extra_last, input bit gapped);
        int i = 0;
        int budget = 0;
        bit v;
        bit acc;
        for (int k = 0; k < N_IN; k++) begin
            frame_mag[k] = (mode == 0) ? W_X'(k % 16) : W_X'($urandom);
            frame_pol[k] = (mode == 0) ? 2'(k % 4) : 2'($urandom);
        end
        while (i < N_IN && budget < 1000) begin
            v = gapped ? ((budget % 2) == 0) : 1'b1;
            s_valid = v;
            s_mag   = frame_mag[i];
            s_pol   = frame_pol[i];
            s_last  = (i == N_IN - 1) || (i == extra_last);
            acc     = v && s_ready;
            tick();
            budget++;
            if (acc) begin
                if (s_last != (i == N_IN - 1)) exp_err = 1'b1;
                i++;
                check_eq("err_len_fill", 64'(err_len), 64'(exp_err));
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check_eq("frame_accepted", 64'(i), 64'(N_IN));
        check_eq("s_ready_after_frame", 64'(s_ready), 64'd0);
    endtask

    // exp_lat < 0 skips the latency check
    task automatic collect_burst(input int exp_lat);
        int lat = 0;
        int n = 0;
        logic [P*W_X-1:0] got_mag [$];
        logic [P*2-1:0]   got_pol [$];
        logic [P*W_X-1:0] em;
        logic [P*2-1:0]   ep;
        while (!in_vld && lat < 60) begin
            tick();
            lat++;
        end
        if (exp_lat >= 0) check_eq("burst_latency", 64'(lat), 64'(exp_lat));
        check_eq("s_ready_in_burst", 64'(s_ready), 64'd0);
        while (in_vld && n < 60) begin
            got_mag.push_back(in_mag);
            got_pol.push_back(in_pol);
            tick();
            n++;
        end
        check_eq("burst_len", 64'(n), 64'(N_BEATS));
        check_eq("idle_zero", 64'({in_mag, in_pol}), 64'd0);
        for (int b = 0; b < n && b < N_BEATS; b++) begin
            em = '0;
            ep = '0;
            for (int p = 0; p < P; p++) begin
                em = em | ((P*W_X)'(frame_mag[b*P+p]) << (p*W_X));
                ep = ep | ((P*2)'(frame_pol[b*P+p]) << (p*2));
            end
            check_eq($sformatf("beat%0d", b), 64'({got_mag[b], got_pol[b]}), 64'({em, ep}));
        end
    endtask

    task automatic pulse_result(input logic [W_Y-1:0] val, input bit rr);
        out_vld = 1'b1;
        out     = val;
        r_ready = rr;
        tick();
        out_vld = 1'b0;
        r_ready = 1'b0;
        exp_rv    = 1'b1;
        exp_rdata = val;
        check_eq("r_valid_capture", 64'(r_valid), 64'(exp_rv));
        check_eq("r_data_capture", 64'(r_data), 64'(exp_rdata));
        check_eq("s_ready_after_capture", 64'(s_ready), 64'd1);
    endtask

    task automatic consume();
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        exp_rv = 1'b0;
        check_eq("r_valid_consumed", 64'(r_valid), 64'(exp_rv));
        check_eq("r_data_held", 64'(r_data), 64'(exp_rdata));
    endtask

    initial begin
        logic [W_Y-1:0] rnd;
        int to;

        // reset / idle
        rst = 1'b1;
        repeat (3) tick();
        check_eq("rst_s_ready", 64'(s_ready), 64'd0);
        check_eq("rst_in_vld", 64'(in_vld), 64'd0);
        check_eq("rst_r_valid", 64'(r_valid), 64'd0);
        check_eq("rst_r_data", 64'(r_data), 64'd0);
        check_eq("rst_err_len", 64'(err_len), 64'd0);
        rst = 1'b0;
        #1;
        check_eq("idle_s_ready", 64'(s_ready), 64'd1);
        repeat (10) begin
            tick();
            check_eq("idle_in_vld", 64'({in_vld, in_mag, in_pol}), 64'd0);
        end

        // nominal frame
        send_frame(0, -1, 1'b0);
        collect_burst(2);
        pulse_result(16'h1234, 1'b0);
        check_eq("nominal_err", 64'(err_len), 64'(exp_err));

        // backpressure: second frame waits in HOLD while the result is unread
        send_frame(1, -1, 1'b0);
        repeat (5) tick();
        check_eq("hold_in_vld", 64'(in_vld), 64'd0);
        check_eq("hold_r_valid", 64'(r_valid), 64'd1);
        check_eq("hold_r_data", 64'(r_data), 64'h1234);
        consume();
        collect_burst(2);
        check_eq("bp_r_data_kept", 64'(r_data), 64'h1234);
        rnd = W_Y'($urandom);
        pulse_result(rnd, 1'b0);
        consume();

        // out_vld during FILL is flagged and ignored, then a gapped frame
        out_vld = 1'b1;
        out     = ~exp_rdata;
        tick();
        out_vld = 1'b0;
        exp_err = 1'b1;
        check_eq("stray_out_err", 64'(err_len), 64'(exp_err));
        check_eq("stray_out_r_data", 64'(r_data), 64'(exp_rdata));
        check_eq("stray_out_r_valid", 64'(r_valid), 64'(exp_rv));
        send_frame(1, -1, 1'b1);
        collect_burst(2);
        rnd = W_Y'($urandom);
        pulse_result(rnd, 1'b0);
        consume();

        // reset mid-burst
        send_frame(1, -1, 1'b0);
        to = 0;
        while (!in_vld && to < 60) begin
            tick();
            to++;
        end
        check_eq("mid_burst_start", 64'(in_vld), 64'd1);
        repeat (10) tick();
        check_eq("mid_burst_active", 64'(in_vld), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("async_in_vld", 64'({in_vld, in_mag, in_pol}), 64'd0);
        check_eq("async_s_ready", 64'(s_ready), 64'd0);
        exp_err = 1'b0;
        exp_rv = 1'b0;
        exp_rdata = '0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check_eq("post_rst_s_ready", 64'(s_ready), 64'd1);
        check_eq("post_rst_err", 64'(err_len), 64'(exp_err));
        check_eq("post_rst_r_data", 64'(r_data), 64'(exp_rdata));
        send_frame(1, -1, 1'b0);
        collect_burst(2);
        // capture wins over a simultaneous r_ready
        rnd = W_Y'($urandom);
        pulse_result(rnd, 1'b1);
        consume();

        // length error: early s_last, then a clean frame keeps err_len sticky
        send_frame(1, 20, 1'b0);
        collect_burst(2);
        pulse_result(W_Y'($urandom), 1'b0);
        consume();
        send_frame(1, -1, 1'b0);
        collect_burst(2);
        check_eq("err_sticky", 64'(err_len), 64'(exp_err));
        pulse_result(W_Y'($urandom), 1'b0);
        consume();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
